handshake_source_tx: RTL and testbench

Source-domain transmitter that feeds the source port of the handshake clock-domain crossing. It accepts words from an upstream valid/ready stream and buffers them in a small FIFO. It presents one word at a time to the crossing, then waits for the crossing's ready to return before the next word is offered. A watchdog flags a crossing that never acknowledges, and a counter reports completed sends.

---
 rtl/handshake_pkg.sv | 5 +
 rtl/handshake_source_tx_sync_fifo.sv | 37 +++
 rtl/handshake_source_tx.sv | 59 +++++
 tb/tb_handshake_source_tx.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// handshake_pkg: shared types and constants for the handshake source transmitter
package handshake_pkg;
  typedef enum logic {IDLE, WAIT_ACK} tx_state_t;
  localparam int SENT_COUNT_WIDTH = 16;
endpackage

// File: rtl/handshake_source_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-bit pointers and a combinational read head
module sync_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         wr_en,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  // storage is cleared on reset so the head reads as zero out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en && !full) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/handshake_source_tx.sv
// handshake_source_tx: buffers an upstream stream and offers one word per crossing handshake
module handshake_source_tx
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(DEPTH+1)-1:0]    level,
  output logic                          busy,
  output logic                          timeout_err,
  input  logic                          err_clr,
  output logic [SENT_COUNT_WIDTH-1:0]   sent_count
);
  localparam int WD_W = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  tx_state_t state, state_nx;
  logic full, empty, pop, wd_hit;
  logic [WD_W-1:0] wd_cnt;
  logic [SENT_COUNT_WIDTH-1:0] sent_q;
  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .wr_data(in_data), .wr_en(in_valid), .rd_en(pop),
    .rd_data(tx_data), .full(full), .empty(empty), .level(level)
  );
  assign in_ready = !full;
  assign busy = !empty || state == WAIT_ACK;
  assign sent_count = sent_q;
  assign wd_hit = TIMEOUT != 0 && state == WAIT_ACK && wd_cnt == WD_W'(TIMEOUT - 1);
  always_comb begin
    tx_valid = state == IDLE && !empty;
    pop = tx_valid && tx_ready;
    state_nx = state == IDLE ? (pop ? WAIT_ACK : IDLE) : (tx_ready ? IDLE : WAIT_ACK);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // watchdog saturates one past its trip point so each transaction flags at most once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_q <= '0;
      wd_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (pop) sent_q <= sent_q + 1'b1;
      if (pop) wd_cnt <= '0;
      else if (state == WAIT_ACK && wd_cnt != WD_W'(TIMEOUT)) wd_cnt <= wd_cnt + 1'b1;
      if (wd_hit) timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_handshake_source_tx.sv
// tb_handshake_source_tx: directed scoreboard bench for the handshake source transmitter
module tb_handshake_source_tx;
  logic clk, rst, in_valid, in_ready, tx_valid, tx_ready, busy, timeout_err, err_clr;
  logic [3:0] in_data, tx_data;
  logic [2:0] level;
  logic [15:0] sent_count;
  logic auto_ack, spacing_on, xfer;
  int checks = 0, errors = 0, cyc = 0, prev = -1, hold = 0, n_xfer = 0, snap;
  logic [3:0] exp_q[$];

  handshake_source_tx #(.DATA_WIDTH(4), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .level(level),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr), .sent_count(sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic acc);
    in_data = d;
    in_valid = 1'b1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, acc});
    if (acc) exp_q.push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // transfer monitor plus a crossing model whose ready drops after each transfer and returns 4 cycles later
  always @(posedge clk) begin
    logic [3:0] e;
    xfer = tx_valid && tx_ready && !rst;
    if (xfer) begin
      n_xfer++;
      chk("xfer_pending", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_data", {28'd0, tx_data}, {28'd0, e});
      end
      if (spacing_on && prev >= 0) chk("spacing", cyc - prev, 32'd2);
      prev = cyc;
    end
    cyc++;
    #1;
    if (auto_ack) begin
      if (xfer) begin
        tx_ready = 1'b0;
        hold = 4;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) tx_ready = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; tx_ready = 1'b0; err_clr = 1'b0;
    auto_ack = 1'b0; spacing_on = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {28'd0, tx_data}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_sent", {16'd0, sent_count}, 32'd0);
    // three words through a crossing-like partner
    auto_ack = 1'b1; tx_ready = 1'b1;
    push(4'h3, 1'b1); push(4'h5, 1'b1); push(4'hA, 1'b1);
    for (int i = 0; i < 100 && sent_count !== 16'd3; i++) @(negedge clk);
    chk("s2_sent", {16'd0, sent_count}, 32'd3);
    chk("s2_busy_wait", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
    chk("s2_busy", {31'd0, busy}, 32'd0);
    chk("s2_level", {29'd0, level}, 32'd0);
    chk("s2_q", exp_q.size(), 32'd0);
    // fill while the crossing is not ready
    auto_ack = 1'b0; tx_ready = 1'b0;
    push(4'h1, 1'b1); push(4'h2, 1'b1); push(4'h4, 1'b1); push(4'h8, 1'b1);
    push(4'hF, 1'b0);
    chk("s3_level_full", {29'd0, level}, 32'd4);
    chk("s3_in_ready", {31'd0, in_ready}, 32'd0);
    chk("s3_tx_valid", {31'd0, tx_valid}, 32'd1);
    prev = -1; spacing_on = 1'b1; tx_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    spacing_on = 1'b0;
    chk("s3_level", {29'd0, level}, 32'd0);
    chk("s3_sent", {16'd0, sent_count}, 32'd7);
    chk("s3_busy", {31'd0, busy}, 32'd0);
    // watchdog trips after the 8th WAIT_ACK cycle
    tx_ready = 1'b0;
    push(4'h7, 1'b1);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    repeat (7) @(negedge clk);
    chk("wd_before", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    chk("wd_set", {31'd0, timeout_err}, 32'd1);
    chk("wd_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("wd_busy", {31'd0, busy}, 32'd1);
    repeat (5) @(negedge clk);
    chk("wd_sticky", {31'd0, timeout_err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("wd_clr", {31'd0, timeout_err}, 32'd0);
    repeat (10) @(negedge clk);
    chk("wd_no_repulse", {31'd0, timeout_err}, 32'd0);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("wd_idle", {31'd0, busy}, 32'd0);
    chk("wd_sent", {16'd0, sent_count}, 32'd8);
    // set beats a simultaneous clear
    tx_ready = 1'b0;
    push(4'h9, 1'b1);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0; err_clr = 1'b1;
    repeat (7) @(negedge clk);
    chk("sw_before", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    chk("sw_set_wins", {31'd0, timeout_err}, 32'd1);
    @(negedge clk);
    err_clr = 1'b0;
    chk("sw_clr_after", {31'd0, timeout_err}, 32'd0);
    // reset in WAIT_ACK with two words queued
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    push(4'hB, 1'b1); push(4'hC, 1'b1);
    chk("mr_level", {29'd0, level}, 32'd2);
    rst = 1'b1;
    #1;
    exp_q.delete();
    snap = n_xfer;
    chk("mr_level0", {29'd0, level}, 32'd0);
    chk("mr_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("mr_tx_data", {28'd0, tx_data}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mr_sent", {16'd0, sent_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0; tx_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("mr_no_send", n_xfer, snap);
    chk("mr_sent_after", {16'd0, sent_count}, 32'd0);
    // sent_count wrap from a preloaded value
    force dut.sent_q = 16'hFFFE;
    #1;
    release dut.sent_q;
    chk("wr_preload", {16'd0, sent_count}, 32'hFFFE);
    push(4'h1, 1'b1);
    @(negedge clk);
    chk("wr_ffff", {16'd0, sent_count}, 32'hFFFF);
    push(4'h2, 1'b1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("wr_zero", {16'd0, sent_count}, 32'd0);
    chk("wr_level", {29'd0, level}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
